// File: rtl/imem_pkg.sv
// Shared types and constants for the fetch-stage instruction memory.
// Holds the FSM state type, the boot image and the default fill word.
package imem_pkg;

   typedef enum logic {BOOT, RUN} state_t;

   localparam int unsigned IMG_LEN = 6;
   localparam logic [7:0] BOOT_IMG [IMG_LEN] = '{8'h1B, 8'h5A, 8'h53, 8'hC1, 8'h1C, 8'h5D};
   localparam logic [7:0] FILL_DEF = 8'h00;

endpackage

// File: rtl/imem_resp_fifo.sv
// Two-entry response FIFO of {instr, pc, err}.
// The entry registers double as the synchronous read register of the RAM.
module imem_resp_fifo
   import imem_pkg::*;
#(
   parameter int INSTR_W = 8,
   parameter int ADDR_W = 8,
   parameter logic [INSTR_W-1:0] RST_INSTR = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               push,
   input  logic [INSTR_W-1:0] push_instr,
   input  logic [ADDR_W-1:0]  push_pc,
   input  logic               push_err,
   input  logic               pop,
   output logic [1:0]         count,
   output logic [INSTR_W-1:0] head_instr,
   output logic [ADDR_W-1:0]  head_pc,
   output logic               head_err
);

   logic [INSTR_W-1:0] ent_instr [2];
   logic [ADDR_W-1:0]  ent_pc [2];
   logic               ent_err [2];
   logic               wr_ptr;
   logic               rd_ptr;
   logic               push_ok;
   logic               pop_ok;

   assign push_ok = push && (count != 2'd2);
   assign pop_ok  = pop && (count != 2'd0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 2; i++) begin
            ent_instr[i] <= RST_INSTR;
            ent_pc[i]    <= '0;
            ent_err[i]   <= 1'b0;
         end
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else if (clear) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) begin
            ent_instr[wr_ptr] <= push_instr;
            ent_pc[wr_ptr]    <= push_pc;
            ent_err[wr_ptr]   <= push_err;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop_ok) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + 2'(push_ok) - 2'(pop_ok);
      end
   end

   assign head_instr = ent_instr[rd_ptr];
   assign head_pc    = ent_pc[rd_ptr];
   assign head_err   = ent_err[rd_ptr];

endmodule

// File: rtl/imem_fetch_buf.sv
// Fetch-stage instruction RAM with boot-image copy, runtime load port and
// a valid/ready fetch interface backed by a two-entry response buffer.
//
// state | meaning
// BOOT  | copying boot image / FILL into RAM, one word per cycle
// RUN   | fetches and program loads accepted
module imem_fetch_buf
   import imem_pkg::*;
#(
   parameter int INSTR_W = 8,
   parameter int ADDR_W = 8,
   parameter int DEPTH = 256,
   parameter logic [INSTR_W-1:0] FILL = INSTR_W'(FILL_DEF)
) (
   input  logic               clk,
   input  logic               rst,
   output logic               boot_done,
   input  logic               req_valid,
   input  logic [ADDR_W-1:0]  req_pc,
   output logic               req_ready,
   output logic               resp_valid,
   output logic [INSTR_W-1:0] resp_instr,
   output logic [ADDR_W-1:0]  resp_pc,
   output logic               resp_err,
   input  logic               resp_ready,
   input  logic               flush,
   input  logic               ld_valid,
   input  logic [ADDR_W-1:0]  ld_addr,
   input  logic [INSTR_W-1:0] ld_data,
   output logic               ld_ready
);

   localparam int IDX_W = $clog2(DEPTH);

   function automatic logic in_range(input logic [ADDR_W-1:0] addr);
      return 32'(addr) < DEPTH;
   endfunction

   state_t             state;
   logic [ADDR_W-1:0]  boot_cnt;
   logic [INSTR_W-1:0] boot_word;
   logic [INSTR_W-1:0] mem [DEPTH];
   logic [1:0]         count;
   logic               pop;
   logic               req_fire;
   logic               req_in;
   logic [INSTR_W-1:0] rd_word;

   always_comb begin
      boot_word = FILL;
      for (int unsigned i = 0; i < IMG_LEN; i++) begin
         if (32'(boot_cnt) == i) boot_word = INSTR_W'(BOOT_IMG[i]);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= BOOT;
         boot_cnt  <= '0;
         boot_done <= 1'b0;
         ld_ready  <= 1'b0;
      end else begin
         case (state)
            BOOT: begin
               boot_cnt <= boot_cnt + 1'b1;
               if (32'(boot_cnt) == DEPTH - 1) begin
                  state     <= RUN;
                  boot_done <= 1'b1;
                  ld_ready  <= 1'b1;
               end
            end
            RUN: state <= RUN;
            default: state <= BOOT;
         endcase
      end
   end

   // Boot and load writes share the single write port; ld_ready is low in BOOT.
   always_ff @(posedge clk) begin
      if (state == BOOT) begin
         mem[boot_cnt[IDX_W-1:0]] <= boot_word;
      end else if (ld_valid && ld_ready && in_range(ld_addr)) begin
         mem[ld_addr[IDX_W-1:0]] <= ld_data;
      end
   end

   // Read data is captured into the buffer at the accept edge, so a
   // same-edge load to the same address is seen as the old word.
   assign req_in    = in_range(req_pc);
   assign rd_word   = req_in ? mem[req_pc[IDX_W-1:0]] : FILL;
   assign pop       = resp_valid && resp_ready;
   assign req_ready = (state == RUN) && !flush && ((count != 2'd2) || pop);
   assign req_fire  = req_valid && req_ready;
   assign resp_valid = (count != 2'd0);

   imem_resp_fifo #(
      .INSTR_W  (INSTR_W),
      .ADDR_W   (ADDR_W),
      .RST_INSTR(FILL)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .push      (req_fire),
      .push_instr(rd_word),
      .push_pc   (req_pc),
      .push_err  (!req_in),
      .pop       (pop),
      .count     (count),
      .head_instr(resp_instr),
      .head_pc   (resp_pc),
      .head_err  (resp_err)
   );

endmodule

// File: tb/tb_imem_fetch_buf.sv
// Directed bench for imem_fetch_buf with DEPTH=8: boot, fetch table,
// back-pressure, read-before-write load, range errors, flush and reset.
module tb_imem_fetch_buf;

   logic       clk = 1'b0;
   logic       rst;
   logic       boot_done;
   logic       req_valid;
   logic [7:0] req_pc;
   logic       req_ready;
   logic       resp_valid;
   logic [7:0] resp_instr;
   logic [7:0] resp_pc;
   logic       resp_err;
   logic       resp_ready;
   logic       flush;
   logic       ld_valid;
   logic [7:0] ld_addr;
   logic [7:0] ld_data;
   logic       ld_ready;

   int n_tests = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   imem_fetch_buf #(.INSTR_W(8), .ADDR_W(8), .DEPTH(8), .FILL(8'h00)) dut (
      .clk       (clk),
      .rst       (rst),
      .boot_done (boot_done),
      .req_valid (req_valid),
      .req_pc    (req_pc),
      .req_ready (req_ready),
      .resp_valid(resp_valid),
      .resp_instr(resp_instr),
      .resp_pc   (resp_pc),
      .resp_err  (resp_err),
      .resp_ready(resp_ready),
      .flush     (flush),
      .ld_valid  (ld_valid),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .ld_ready  (ld_ready)
   );

   typedef struct {
      logic [7:0] pc;
      logic [7:0] instr;
      logic       err;
   } vec_t;

   vec_t vt[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_boot(input string name);
      int n = 0;
      while (n < 50) begin
         @(posedge clk);
         #1;
         n++;
         if (boot_done) break;
      end
      chk(name, 32'(n), 32'd8);
   endtask

   task automatic fetch_one(input string name, input logic [7:0] pc,
                            input logic [7:0] instr, input logic err);
      @(negedge clk);
      chk({name, "_rdy"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_pc    = pc;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk({name, "_valid"}, 32'(resp_valid), 32'd1);
      chk({name, "_instr"}, 32'(resp_instr), 32'(instr));
      chk({name, "_pc"}, 32'(resp_pc), 32'(pc));
      chk({name, "_err"}, 32'(resp_err), 32'(err));
   endtask

   initial begin
      logic [7:0] img [8];
      logic       exp_rdy [4];
      logic       rdy;
      logic [7:0] pc;

      img = '{8'h1B, 8'h5A, 8'h53, 8'hC1, 8'h1C, 8'h5D, 8'h00, 8'h00};
      for (int i = 0; i < 8; i++) vt[i] = '{pc: 8'(i), instr: img[i], err: 1'b0};
      vt[8]  = '{pc: 8'd9,   instr: 8'h00, err: 1'b1};
      vt[9]  = '{pc: 8'd8,   instr: 8'h00, err: 1'b1};
      vt[10] = '{pc: 8'd255, instr: 8'h00, err: 1'b1};
      exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0};

      rst = 1'b0;
      req_valid = 1'b0;
      req_pc = '0;
      resp_ready = 1'b1;
      flush = 1'b0;
      ld_valid = 1'b0;
      ld_addr = '0;
      ld_data = '0;

      #3;
      chk("rst_boot_done", 32'(boot_done), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_ld_ready", 32'(ld_ready), 32'd0);
      chk("rst_resp_instr", 32'(resp_instr), 32'd0);
      chk("rst_resp_pc", 32'(resp_pc), 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);

      // Reset in the middle of BOOT, then a full boot.
      @(negedge clk) rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      @(negedge clk) rst = 1'b1;
      wait_boot("boot_cycles");
      chk("run_ld_ready", 32'(ld_ready), 32'd1);

      for (int i = 0; i < 11; i++) begin
         fetch_one($sformatf("tbl%0d", i), vt[i].pc, vt[i].instr, vt[i].err);
      end

      // Back-to-back fetches pc 0..5.
      @(negedge clk);
      req_valid = 1'b1;
      req_pc = 8'd0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         if (k < 5) req_pc = 8'(k + 1);
         else req_valid = 1'b0;
         @(negedge clk);
         chk($sformatf("b2b%0d_valid", k), 32'(resp_valid), 32'd1);
         chk($sformatf("b2b%0d_pc", k), 32'(resp_pc), 32'(k));
         chk($sformatf("b2b%0d_instr", k), 32'(resp_instr), 32'(img[k]));
      end
      @(negedge clk);
      chk("b2b_empty", 32'(resp_valid), 32'd0);

      // Back-pressure: two accepts then stall, head held stable.
      resp_ready = 1'b0;
      req_valid = 1'b1;
      pc = 8'd2;
      req_pc = pc;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         chk($sformatf("bp%0d_rdy", c), 32'(req_ready), 32'(exp_rdy[c]));
         if (c > 0) begin
            chk($sformatf("bp%0d_head_pc", c), 32'(resp_pc), 32'd2);
            chk($sformatf("bp%0d_head_instr", c), 32'(resp_instr), 32'h53);
         end
         rdy = req_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            pc = pc + 8'd1;
            req_pc = pc;
         end
      end
      req_valid = 1'b0;
      @(negedge clk);
      resp_ready = 1'b1;
      chk("drain0_pc", 32'(resp_pc), 32'd2);
      chk("drain0_instr", 32'(resp_instr), 32'h53);
      @(negedge clk);
      chk("drain1_valid", 32'(resp_valid), 32'd1);
      chk("drain1_pc", 32'(resp_pc), 32'd3);
      chk("drain1_instr", 32'(resp_instr), 32'hC1);
      @(negedge clk);
      chk("drain_empty", 32'(resp_valid), 32'd0);

      // Same-cycle load and fetch of addr 3: old word returned.
      @(negedge clk);
      chk("rbw_ld_ready", 32'(ld_ready), 32'd1);
      ld_valid = 1'b1;
      ld_addr = 8'd3;
      ld_data = 8'hA5;
      req_valid = 1'b1;
      req_pc = 8'd3;
      @(posedge clk);
      #1;
      ld_valid = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      chk("rbw_old", 32'(resp_instr), 32'hC1);
      fetch_one("rbw_new", 8'd3, 8'hA5, 1'b0);

      // Out-of-range load is dropped.
      @(negedge clk);
      ld_valid = 1'b1;
      ld_addr = 8'd9;
      ld_data = 8'hFF;
      @(posedge clk);
      #1 ld_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         fetch_one($sformatf("oor_ld%0d", i), 8'(i), (i == 3) ? 8'hA5 : img[i], 1'b0);
      end

      // Flush with a full buffer.
      @(negedge clk);
      resp_ready = 1'b0;
      req_valid = 1'b1;
      req_pc = 8'd0;
      @(posedge clk);
      #1 req_pc = 8'd1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("fl_full_valid", 32'(resp_valid), 32'd1);
      chk("fl_full_rdy", 32'(req_ready), 32'd0);
      flush = 1'b1;
      req_valid = 1'b1;
      req_pc = 8'd2;
      resp_ready = 1'b1;
      chk("fl_rdy_in_flush", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      chk("fl_empty", 32'(resp_valid), 32'd0);
      fetch_one("fl_after", 8'd5, 8'h5D, 1'b0);

      // Reset mid-RUN restores the boot image.
      @(negedge clk) rst = 1'b0;
      #1;
      chk("rr_boot_done", 32'(boot_done), 32'd0);
      chk("rr_resp_valid", 32'(resp_valid), 32'd0);
      @(negedge clk) rst = 1'b1;
      wait_boot("reboot_cycles");
      fetch_one("rr_pc3", 8'd3, 8'hC1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: sim time limit reached, expected finish");
      $fatal(1, "timeout");
   end

endmodule
